bird_physics_controller: RTL and testbench
==========================================

// Module: bird_physics_controller
// PURPOSE
//   Writer side of bird_reg: owns the bird's vertical position and velocity and publishes the top edge
//   consumed by the bird renderer. Applies gravity and flap impulses once per video frame.
//   Runs the IDLE/PLAYING/DEAD game state. Sits between input handling (flap/start/collision) and the VGA
//   image layer.
// PARAMETERS
//   SCREEN_HEIGHT   480  visible rows
//   BIRD_HEIGHT     35   sprite height in rows
//   START_Y         200  top edge on reset / restart
//   GRAVITY         1    velocity increment per frame (rows/frame)
//   FLAP_SPEED      8    upward speed set by a flap (velocity := -FLAP_SPEED)
//   MAX_FALL_SPEED  10   downward velocity ceiling
// PORTS
//   clk            in   1   system clock (single domain)
//   resetn         in   1   synchronous, active-low reset
//   frame_tick     in   1   one-cycle pulse per frame (end of visible area)
//   flap           in   1   flap button level, already synchronised to clk
//   start          in   1   start/restart button level, already synchronised
//   collision      in   1   bird/pipe overlap flag from display logic
//   bird_reg       out  32  [8:0] bird top edge row, [31:9] always 0
//   bird_velocity  out  8   signed rows/frame, +ve = down
//   playing        out  1   state == PLAYING
//   dead           out  1   state == DEAD
// BEHAVIOUR
//   - Reset (resetn=0 at posedge): state IDLE, y=START_Y, vel=0, flap_pending=0, edge detect regs=0;
//     bird_reg=START_Y, bird_velocity=0, playing=0, dead=0.
//   - Flap and start are rising-edge detected (registered previous level). A flap edge sets flap_pending.
//   - flap_pending is held until the next frame_tick consumed in PLAYING, then cleared.
//   - Multiple flap edges within one frame count as one.
//   - IDLE: y, vel frozen. A start edge or flap edge -> PLAYING next cycle. A flap edge also sets
//     flap_pending. Ticks in IDLE are ignored.
//   - PLAYING, on frame_tick:
//     - vel_n = flap_pending ? -FLAP_SPEED : min(vel+GRAVITY, MAX_FALL_SPEED).
//     - y_n = y + vel_n, computed signed with 11 bits (no wrap).
//     - y_n < 0: y=0, vel=0 (ceiling clamp, still PLAYING).
//     - y_n >= SCREEN_HEIGHT-BIRD_HEIGHT: y=SCREEN_HEIGHT-BIRD_HEIGHT, vel=0, state -> DEAD.
//     - Otherwise y=y_n, vel=vel_n.
//   - PLAYING, collision=1 on any cycle -> DEAD next cycle.
//     - If frame_tick is in the same cycle, collision wins: no position/velocity update.
//   - DEAD: y, vel frozen, flaps ignored and flap_pending cleared. A start edge -> IDLE with y=START_Y,
//     vel=0.
//   - A start edge in PLAYING is ignored.
//   - Latency: all outputs are registered and update 1 cycle after the triggering edge/tick.
//   - bird_reg is always a valid row in [0, SCREEN_HEIGHT-BIRD_HEIGHT].
//   - Reset mid-frame or mid-game fully restores reset values on the next posedge; the pending flap is
//     discarded.
// TESTING
//   1. Hold resetn=0 for 2 cycles -> bird_reg=200, bird_velocity=0, playing=0, dead=0.
//   2. start pulse, then 3 frame_ticks with no flap -> vel 1,2,3; bird_reg 201,203,206; each value
//      appears 1 cycle after its tick.
//   3. Then 2 flap edges, then tick -> vel=-8, bird_reg=198. Next tick with no flap -> vel=-7,
//      bird_reg=191.
//   4. Force y=5 via flaps, flap+tick -> bird_reg=0, vel=0, playing stays 1.
//   5. Free-fall until floor -> bird_reg clamps at 445, dead=1. Further ticks and flaps leave bird_reg=445.
//   6. collision=1 together with frame_tick at y=300 -> dead=1, bird_reg=300.
//      start -> IDLE, bird_reg=200. resetn=0 during PLAYING -> bird_reg=200, playing=0 next cycle.

Source files
------------

// File: rtl/bird_physics_controller.sv
// bird_physics_controller
//   Owns the bird's vertical position and velocity and runs the IDLE/PLAYING/DEAD game state.
//   Gravity and flap impulses are applied once per video frame (frame_tick). All outputs are
//   registered and change one cycle after the edge or tick that causes them.
// Ports
//   clk           : system clock
//   resetn        : synchronous active-low reset
//   frame_tick    : one-cycle pulse per frame
//   flap          : flap button level (synchronised)
//   start         : start/restart button level (synchronised)
//   collision     : bird/pipe overlap flag
//   bird_reg      : [8:0] bird top edge row, [31:9] zero
//   bird_velocity : signed rows/frame, positive = downward
//   playing       : game state is PLAYING
//   dead          : game state is DEAD
module bird_physics_controller #(
    parameter int SCREEN_HEIGHT  = 480,
    parameter int BIRD_HEIGHT    = 35,
    parameter int START_Y        = 200,
    parameter int GRAVITY        = 1,
    parameter int FLAP_SPEED     = 8,
    parameter int MAX_FALL_SPEED = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        start,
    input  logic        collision,
    output logic [31:0] bird_reg,
    output logic [7:0]  bird_velocity,
    output logic        playing,
    output logic        dead
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAYING,
        ST_DEAD
    } state_t;

    localparam logic signed [10:0] FLOOR_S    = 11'(SCREEN_HEIGHT - BIRD_HEIGHT);
    localparam logic signed [10:0] GRAVITY_S  = 11'(GRAVITY);
    localparam logic signed [10:0] MAX_FALL_S = 11'(MAX_FALL_SPEED);
    localparam logic signed [10:0] FLAP_VEL_S = -11'(FLAP_SPEED);

    state_t             state_q, state_d;
    logic [8:0]         y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic               pend_q, pend_d;
    logic               flap_prev_q, start_prev_q;
    logic               playing_q, playing_d;
    logic               dead_q, dead_d;

    logic               flap_edge, start_edge;
    logic signed [10:0] vel_inc, vel_new, y_next;

    always_comb begin
        flap_edge  = flap & ~flap_prev_q;
        start_edge = start & ~start_prev_q;

        // A flap edge arriving in the same cycle as the tick still counts for this frame.
        vel_inc = {{3{vel_q[7]}}, vel_q} + GRAVITY_S;
        if (pend_q || flap_edge)
            vel_new = FLAP_VEL_S;
        else if (vel_inc > MAX_FALL_S)
            vel_new = MAX_FALL_S;
        else
            vel_new = vel_inc;
        y_next = $signed({2'b00, y_q}) + vel_new;

        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        pend_d  = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (flap_edge)
                    pend_d = 1'b1;
                if (flap_edge || start_edge)
                    state_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                // Collision takes priority over a coincident frame tick.
                if (collision) begin
                    state_d = ST_DEAD;
                    pend_d  = 1'b0;
                end else if (frame_tick) begin
                    pend_d = 1'b0;
                    if (y_next < 0) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else if (y_next >= FLOOR_S) begin
                        y_d     = FLOOR_S[8:0];
                        vel_d   = '0;
                        state_d = ST_DEAD;
                    end else begin
                        y_d   = y_next[8:0];
                        vel_d = vel_new[7:0];
                    end
                end else if (flap_edge) begin
                    pend_d = 1'b1;
                end
            end
            ST_DEAD: begin
                pend_d = 1'b0;
                if (start_edge) begin
                    state_d = ST_IDLE;
                    y_d     = 9'(START_Y);
                    vel_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        playing_d = (state_d == ST_PLAYING);
        dead_d    = (state_d == ST_DEAD);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            y_q          <= 9'(START_Y);
            vel_q        <= '0;
            pend_q       <= 1'b0;
            flap_prev_q  <= 1'b0;
            start_prev_q <= 1'b0;
            playing_q    <= 1'b0;
            dead_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            pend_q       <= pend_d;
            flap_prev_q  <= flap;
            start_prev_q <= start;
            playing_q    <= playing_d;
            dead_q       <= dead_d;
        end
    end

    assign bird_reg      = {23'b0, y_q};
    assign bird_velocity = vel_q;
    assign playing       = playing_q;
    assign dead          = dead_q;

endmodule

// File: tb/tb_bird_physics_controller.sv
// Testbench for bird_physics_controller: directed game scenarios with literal expectations,
// then randomized stimulus, all compared every cycle against a behavioural game model.
module tb_bird_physics_controller;

    logic        clk = 1'b0;
    logic        resetn, frame_tick, flap, start, collision;
    logic [31:0] bird_reg;
    logic [7:0]  bird_velocity;
    logic        playing, dead;

    bird_physics_controller #(
        .SCREEN_HEIGHT (480),
        .BIRD_HEIGHT   (35),
        .START_Y       (200),
        .GRAVITY       (1),
        .FLAP_SPEED    (8),
        .MAX_FALL_SPEED(10)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .flap         (flap),
        .start        (start),
        .collision    (collision),
        .bird_reg     (bird_reg),
        .bird_velocity(bird_velocity),
        .playing      (playing),
        .dead         (dead)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: game mode 0=idle 1=playing 2=dead, plain integer physics
    int m_mode = 0;
    int m_y    = 200;
    int m_vel  = 0;
    bit m_pend = 1'b0;
    bit m_pf   = 1'b0;
    bit m_ps   = 1'b0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit fe, se;
        int v, ny;
        if (!resetn) begin
            m_mode = 0; m_y = 200; m_vel = 0; m_pend = 0; m_pf = 0; m_ps = 0;
            return;
        end
        fe = flap && !m_pf;
        se = start && !m_ps;
        if (m_mode == 0) begin
            if (fe) m_pend = 1;
            if (fe || se) m_mode = 1;
        end else if (m_mode == 1) begin
            if (collision) begin
                m_mode = 2;
                m_pend = 0;
            end else if (frame_tick) begin
                if (m_pend || fe) v = -8;
                else v = (m_vel + 1 > 10) ? 10 : m_vel + 1;
                ny = m_y + v;
                if (ny < 0) begin
                    m_y = 0; m_vel = 0;
                end else if (ny >= 445) begin
                    m_y = 445; m_vel = 0; m_mode = 2;
                end else begin
                    m_y = ny; m_vel = v;
                end
                m_pend = 0;
            end else if (fe) begin
                m_pend = 1;
            end
        end else begin
            m_pend = 0;
            if (se) begin
                m_mode = 0; m_y = 200; m_vel = 0;
            end
        end
        m_pf = flap;
        m_ps = start;
    endtask

    // One clock cycle: drive on the falling edge, advance the model at the rising edge.
    task automatic step(input bit rn, input bit tk, input bit fl, input bit st, input bit co);
        @(negedge clk);
        resetn = rn; frame_tick = tk; flap = fl; start = st; collision = co;
        @(posedge clk);
        model_update();
        chk_en = 1'b1;
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("bird_reg", bird_reg, m_y);
            chk("bird_velocity", $signed(bird_velocity), m_vel);
            chk("playing", {31'b0, playing}, (m_mode == 1) ? 1 : 0);
            chk("dead", {31'b0, dead}, (m_mode == 2) ? 1 : 0);
        end
    end

    initial begin
        int n;
        bit fl_l, st_l;
        resetn = 0; frame_tick = 0; flap = 0; start = 0; collision = 0;

        // Reset
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_bird", bird_reg, 200);
        chk("rst_vel", $signed(bird_velocity), 0);
        chk("rst_playing", {31'b0, playing}, 0);
        chk("rst_dead", {31'b0, dead}, 0);

        // Start, three free-fall frames
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("start_playing", {31'b0, playing}, 1);
        step(1, 1, 0, 0, 0);
        chk("fall1_y", bird_reg, 201);
        chk("fall1_v", $signed(bird_velocity), 1);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("fall2_y", bird_reg, 203);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("fall3_y", bird_reg, 206);
        chk("fall3_v", $signed(bird_velocity), 3);

        // Two flap edges in one frame act once
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("flap_y", bird_reg, 198);
        chk("flap_v", $signed(bird_velocity), -8);
        step(1, 1, 0, 0, 0);
        chk("after_flap_y", bird_reg, 191);
        chk("after_flap_v", $signed(bird_velocity), -7);

        // Climb until close to the ceiling, then flap past it
        n = 0;
        while (m_y >= 8 && n < 60) begin
            step(1, 0, 1, 0, 0);
            step(1, 1, 0, 0, 0);
            n++;
        end
        step(1, 1, 1, 0, 0);
        chk("ceil_y", bird_reg, 0);
        chk("ceil_v", $signed(bird_velocity), 0);
        chk("ceil_playing", {31'b0, playing}, 1);
        step(1, 0, 0, 0, 0);

        // Free fall to the floor
        n = 0;
        while (m_mode == 1 && n < 100) begin
            step(1, 1, 0, 0, 0);
            n++;
        end
        chk("floor_y", bird_reg, 445);
        chk("floor_dead", {31'b0, dead}, 1);
        chk("floor_v", $signed(bird_velocity), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        chk("floor_hold_y", bird_reg, 445);

        // Restart, fall 14 frames to y=295, collide on a tick
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("restart_y", bird_reg, 200);
        chk("restart_idle", {31'b0, playing}, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 0);
        chk("pre_coll_y", bird_reg, 295);
        step(1, 1, 0, 0, 1);
        chk("coll_dead", {31'b0, dead}, 1);
        chk("coll_y", bird_reg, 295);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("coll_restart_y", bird_reg, 200);

        // Reset in the middle of a game
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("midrst_y", bird_reg, 200);
        chk("midrst_playing", {31'b0, playing}, 0);

        // Randomized play
        fl_l = 0; st_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2, 0) == 0) fl_l = ~fl_l;
            if ($urandom_range(24, 0) == 0) st_l = ~st_l;
            step(($urandom_range(499, 0) != 0),
                 ($urandom_range(3, 0) == 0),
                 fl_l, st_l,
                 ($urandom_range(59, 0) == 0));
        end

        chk_en = 1'b0;
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
